// File: rtl/keccak_arbiter_pkg.sv
// Shared types for the Keccak core arbiter: state word, requester indices, FSM states.
package keccak_arbiter_pkg;

  localparam int unsigned KECCAK_W     = 1600;
  localparam int unsigned N_KECCAK_REQ = 3;

  localparam int unsigned REQ_HASHG   = 0;
  localparam int unsigned REQ_SAMPLEA = 1;
  localparam int unsigned REQ_CBD     = 2;

  typedef logic [KECCAK_W-1:0] keccak_1600_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/keccak_arbiter_if.sv
// Requester-side bus of the Keccak arbiter: request levels, input states, grant/done, result.
interface keccak_arbiter_if
  import keccak_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_KECCAK_REQ
);

  logic         [N_REQ-1:0] req_i;
  keccak_1600_t [N_REQ-1:0] din_i;
  logic         [N_REQ-1:0] gnt_o;
  logic         [N_REQ-1:0] done_o;
  keccak_1600_t             dout_o;

  modport master (
    output req_i, din_i,
    input  gnt_o, done_o, dout_o
  );

  modport slave (
    input  req_i, din_i,
    output gnt_o, done_o, dout_o
  );

endinterface

// File: rtl/keccak_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping.
module keccak_arbiter_rr_picker
  import keccak_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_KECCAK_REQ,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_c,
  output logic [PTR_W-1:0] idx_c,
  output logic             any_c
);

  always_comb begin
    int unsigned j;
    logic [PTR_W-1:0] j_idx;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = 32'(ptr_i) + k;
      if (j >= N_REQ) j = j - N_REQ;
      j_idx = PTR_W'(j);
      if (!any_c && req_i[j_idx]) begin
        any_c        = 1'b1;
        idx_c        = j_idx;
        gnt_c[j_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Round-robin arbiter sharing one Keccak-f[1600] core between ML-KEM requesters.
// Optional WAIT watchdog with sticky err_o: define KECCAK_ARB_TIMEOUT_EN.
module keccak_arbiter
  import keccak_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = N_KECCAK_REQ,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  keccak_arbiter_if.slave req_if,
  output logic            busy_o,
  output logic            err_o,
  output logic            core_run_o,
  output keccak_1600_t    core_din_o,
  input  logic            core_ready_i,
  input  keccak_1600_t    core_dout_i
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  if (N_REQ < 2 || TIMEOUT < 1) begin : g_cfg_check
    $error("keccak_arbiter: N_REQ must be >= 2 and TIMEOUT >= 1");
  end

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  keccak_1600_t     dout_q, dout_d;
  keccak_1600_t     core_din_q, core_din_d;
  logic             run_q, run_d;
  logic             busy_q, busy_d;
  logic             rdy_prev_q;
  logic             first_q, first_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             complete_c;
  logic             timeout_c;

  keccak_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i (req_if.req_i),
    .ptr_i (ptr_q),
    .gnt_c (pick_gnt),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  // Rising edge of Ready; the first WAIT cycle is masked against a stale edge.
  assign complete_c = (state_q == ARB_WAIT) && !first_q && core_ready_i && !rdy_prev_q;

`ifdef KECCAK_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_c = (state_q == ARB_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | (timeout_c & ~complete_c);
    if (state_q == ARB_START) begin
      cnt_d = '0;
    end else if (state_q == ARB_WAIT && !timeout_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_c = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (pick_any) state_d = ARB_START;
      ARB_START: state_d = ARB_WAIT;
      ARB_WAIT:  if (complete_c || timeout_c) state_d = ARB_DONE;
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    dout_d     = dout_q;
    core_din_d = core_din_q;
    run_d      = 1'b0;
    first_d    = 1'b0;
    busy_d     = (state_d != ARB_IDLE);
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gidx_d     = pick_idx;
          gnt_d      = pick_gnt;
          core_din_d = req_if.din_i[pick_idx];
          run_d      = 1'b1;
        end
      end
      ARB_START: first_d = 1'b1;
      ARB_WAIT: begin
        if (complete_c) begin
          dout_d = core_dout_i;
          done_d = gnt_q;
        end else if (timeout_c) begin
          dout_d = '0;
          done_d = gnt_q;
        end
      end
      ARB_DONE: begin
        gnt_d = '0;
        ptr_d = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q      <= '0;
      gidx_q     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      dout_q     <= '0;
      core_din_q <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdy_prev_q <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      dout_q     <= dout_d;
      core_din_q <= core_din_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      rdy_prev_q <= core_ready_i;
      first_q    <= first_d;
    end
  end

  assign req_if.gnt_o  = gnt_q;
  assign req_if.done_o = done_q;
  assign req_if.dout_o = dout_q;
  assign busy_o        = busy_q;
  assign core_run_o    = run_q;
  assign core_din_o    = core_din_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Scoreboard bench for keccak_arbiter with a mock Keccak core (Ready drops on run, rises later).
module tb_keccak_arbiter;
  import keccak_arbiter_pkg::*;

  localparam int unsigned N   = N_KECCAK_REQ;
  localparam int unsigned TMO = 64;
  localparam logic [63:0] MIX = 64'h9E37_79B9_7F4A_7C15;

  typedef struct {
    int unsigned  idx;
    keccak_1600_t dout;
    int unsigned  lat;
  } exp_t;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         core_ready = 1'b1;
  keccak_1600_t core_dout  = '0;
  logic         core_run, busy, err;
  keccak_1600_t core_din;

  keccak_arbiter_if #(.N_REQ(N)) bus ();

  keccak_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_if       (bus),
    .busy_o       (busy),
    .err_o        (err),
    .core_run_o   (core_run),
    .core_din_o   (core_din),
    .core_ready_i (core_ready),
    .core_dout_i  (core_dout)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  int unsigned  cyc = 0;
  exp_t         exp_q[$];
  keccak_1600_t din_m [N];
  int unsigned  mptr = 0;

  bit          mon_en = 0, in_op = 0, chk_idle = 0;
  int unsigned gnt_cyc = 0, run_cnt = 0;

  int unsigned mock_lat = 24;
  bit          glitch_mode = 0, hang_mode = 0, mbusy = 0;
  int unsigned mcnt = 0;

  function automatic keccak_1600_t perm(input keccak_1600_t x);
    return {x[1598:0], x[1599]} ^ {25{MIX}};
  endfunction

  function automatic keccak_1600_t rnd1600();
    keccak_1600_t r;
    r = '0;
    for (int w = 0; w < 50; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(input int unsigned i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (low 64 bits) at cycle %0d", name, act[63:0], exp[63:0], cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Mock core: Ready low from the run edge, high again mock_lat edges later.
  always @(posedge clk) begin
    if (core_run) begin
      mbusy      <= 1'b1;
      mcnt       <= mock_lat;
      core_ready <= glitch_mode;
      core_dout  <= perm(core_din);
    end else if (mbusy) begin
      if (mcnt == 1 && !hang_mode) begin
        core_ready <= 1'b1;
        mbusy      <= 1'b0;
      end else begin
        mcnt       <= (mcnt > 0) ? mcnt - 1 : 0;
        core_ready <= 1'b0;
      end
    end else if (glitch_mode) begin
      core_ready <= 1'b0;
    end
  end

  // Monitor: compares grants and completions against the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_idle) begin
        chk_idle = 0;
        chk("busy_after_done", 1600'(busy), 1600'(0));
        chk("gnt_after_done", 1600'(bus.gnt_o), 1600'(0));
        chk("done_one_cycle", 1600'(bus.done_o), 1600'(0));
      end
      if (!in_op && bus.gnt_o != '0) begin
        in_op   = 1;
        gnt_cyc = cyc;
        run_cnt = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", 1600'(bus.gnt_o), 1600'(0));
        end else begin
          chk("gnt_order", 1600'(bus.gnt_o), 1600'(onehot(exp_q[0].idx)));
          chk("core_din", core_din, din_m[exp_q[0].idx]);
          chk("busy_in_op", 1600'(busy), 1600'(1));
        end
      end
      if (in_op && core_run) run_cnt++;
      if (bus.done_o != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1600'(bus.done_o), 1600'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_vec", 1600'(bus.done_o), 1600'(onehot(e.idx)));
          chk("gnt_at_done", 1600'(bus.gnt_o), 1600'(onehot(e.idx)));
          chk("dout", bus.dout_o, e.dout);
          chk("latency", 1600'(cyc - gnt_cyc), 1600'(e.lat));
          chk("run_pulses", 1600'(run_cnt), 1600'(1));
        end
        in_op    = 0;
        chk_idle = 1;
      end
    end
  end

  // Raise mask together and hold each request until its done; expected order is round-robin from mptr.
  task automatic phase(input logic [N-1:0] mask, input int unsigned lat, input bit tmo);
    logic [N-1:0] pend;
    int unsigned  last;
    int unsigned  budget;
    last     = mptr;
    mock_lat = lat;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        din_m[i]      = rnd1600();
        bus.din_i[i]  = din_m[i];
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (mptr + k) % N;
      if (mask[j]) begin
        exp_t e;
        e.idx  = j;
        e.dout = tmo ? '0 : perm(din_m[j]);
        e.lat  = tmo ? TMO + 1 : lat + 2;
        exp_q.push_back(e);
        last = j;
      end
    end
    mptr   = (last + 1) % N;
    budget = N * (lat + TMO + 10);
    pend   = mask;
    bus.req_i = pend;
    for (int unsigned c = 0; c < budget && pend != '0; c++) begin
      @(negedge clk);
      pend      = pend & ~bus.done_o;
      bus.req_i = pend;
    end
    if (pend != '0) begin
      chk("phase_budget", 1600'(pend), 1600'(0));
      bus.req_i = '0;
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_i = '0;
    bus.din_i = '0;
    for (int i = 0; i < N; i++) din_m[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 1600'(bus.gnt_o), 1600'(0));
    chk("rst_done", 1600'(bus.done_o), 1600'(0));
    chk("rst_busy", 1600'(busy), 1600'(0));
    chk("rst_err", 1600'(err), 1600'(0));
    chk("rst_run", 1600'(core_run), 1600'(0));
    chk("rst_dout", bus.dout_o, '0);
    chk("rst_core_din", core_din, '0);
    rst_n  = 1'b1;
    mon_en = 1;
    @(negedge clk);

    phase(3'b111, 24, 0);
    phase(3'b111, 24, 0);
    phase(3'b010, 24, 0);
    phase(3'b011, 24, 0);
    phase(3'b001, 24, 0);

    glitch_mode = 1;
    phase(3'b100, 10, 0);
    phase(3'b011, 5, 0);
    glitch_mode = 0;

    repeat (30) phase(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(3, 30), 0);
    chk("err_after_random", 1600'(err), 1600'(0));

    // Abort an operation in WAIT with ptr at 1, then confirm ptr restarts at 0.
    phase(3'b001, 8, 0);
    mon_en   = 0;
    mock_lat = 40;
    bus.din_i[2] = rnd1600();
    bus.req_i    = 3'b100;
    for (int c = 0; c < 10 && bus.gnt_o == '0; c++) @(negedge clk);
    chk("abort_gnt", 1600'(bus.gnt_o), 1600'(3'b100));
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", 1600'(busy), 1600'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_gnt_clr", 1600'(bus.gnt_o), 1600'(0));
    chk("abort_busy_clr", 1600'(busy), 1600'(0));
    chk("abort_done_clr", 1600'(bus.done_o), 1600'(0));
    bus.req_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    in_op    = 0;
    chk_idle = 0;
    mptr     = 0;
    mon_en   = 1;
    @(negedge clk);
    phase(3'b011, 24, 0);

    hang_mode = 1;
`ifdef KECCAK_ARB_TIMEOUT_EN
    phase(3'b001, 24, 1);
    chk("err_set", 1600'(err), 1600'(1));
    repeat (5) @(negedge clk);
    chk("err_sticky", 1600'(err), 1600'(1));
    rst_n = 1'b0;
    #1;
    chk("err_reset", 1600'(err), 1600'(0));
`else
    din_m[0]     = rnd1600();
    bus.din_i[0] = din_m[0];
    exp_q.push_back('{idx: 0, dout: perm(din_m[0]), lat: 26});
    bus.req_i = 3'b001;
    repeat (150) @(negedge clk);
    chk("hang_busy", 1600'(busy), 1600'(1));
    chk("hang_no_done", 1600'(bus.done_o), 1600'(0));
    chk("hang_err", 1600'(err), 1600'(0));
    mon_en = 0;
    rst_n  = 1'b0;
    bus.req_i = '0;
    exp_q.delete();
`endif
    hang_mode = 0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
